// File: rtl/bas_seq_ctrl.sv
// bas_seq_ctrl: iteration sequencer for the bf16 Beetle Antennae Search datapath.
// Steps antenna, shared fitness and update units via go/done handshakes and tracks best fitness.
module bas_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  count,
    input  logic [8:0]  seed1,
    input  logic [8:0]  seed2,
    output logic [8:0]  dir_x,
    output logic [8:0]  dir_y,
    output logic        ant_go,
    input  logic        ant_done,
    output logic        fit_go,
    output logic        fit_sel,
    input  logic        fit_done,
    input  logic [15:0] fit_res,
    output logic        upd_go,
    output logic        upd_sgn,
    input  logic        upd_done,
    output logic [15:0] f_best,
    output logic [31:0] clk_cnt,
    output logic        busy,
    output logic        done
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_SEED     = 4'd1;
    localparam logic [3:0] S_DIR      = 4'd2;
    localparam logic [3:0] S_ANT_REQ  = 4'd3;
    localparam logic [3:0] S_ANT_WAIT = 4'd4;
    localparam logic [3:0] S_FL_REQ   = 4'd5;
    localparam logic [3:0] S_FL_WAIT  = 4'd6;
    localparam logic [3:0] S_FR_REQ   = 4'd7;
    localparam logic [3:0] S_FR_WAIT  = 4'd8;
    localparam logic [3:0] S_CMP      = 4'd9;
    localparam logic [3:0] S_UPD_REQ  = 4'd10;
    localparam logic [3:0] S_UPD_WAIT = 4'd11;
    localparam logic [3:0] S_CHK      = 4'd12;
    localparam logic [3:0] S_DONE     = 4'd13;

    logic [3:0]  state, nxt;
    logic [8:0]  rem;
    logic [15:0] fl, fr, m;
    logic        fr_lt;

    // bf16 less-than: NaN compares false, +0 and -0 are equal
    function automatic logic lt(input logic [15:0] a, input logic [15:0] b);
        logic nan_a, nan_b;
        nan_a = (&a[14:7]) && (|a[6:0]);
        nan_b = (&b[14:7]) && (|b[6:0]);
        if (nan_a || nan_b)
            return 1'b0;
        if (a[14:0] == 15'd0 && b[14:0] == 15'd0)
            return 1'b0;
        if (a[15] != b[15])
            return a[15];
        return a[15] ? (a[14:0] > b[14:0]) : (a[14:0] < b[14:0]);
    endfunction

    assign fr_lt = lt(fr, fl);
    assign m     = fr_lt ? fr : fl;
    assign busy  = (state != S_IDLE) && (state != S_DONE);
    assign done  = (state == S_DONE);

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE: nxt = start ? S_SEED : state;
            S_SEED:         nxt = (count == 9'd0) ? S_DONE : S_DIR;
            S_DIR:          nxt = S_ANT_REQ;
            S_ANT_REQ:      nxt = S_ANT_WAIT;
            S_ANT_WAIT:     nxt = ant_done ? S_FL_REQ : S_ANT_WAIT;
            S_FL_REQ:       nxt = S_FL_WAIT;
            S_FL_WAIT:      nxt = fit_done ? S_FR_REQ : S_FL_WAIT;
            S_FR_REQ:       nxt = S_FR_WAIT;
            S_FR_WAIT:      nxt = fit_done ? S_CMP : S_FR_WAIT;
            S_CMP:          nxt = S_UPD_REQ;
            S_UPD_REQ:      nxt = S_UPD_WAIT;
            S_UPD_WAIT:     nxt = upd_done ? S_CHK : S_UPD_WAIT;
            S_CHK:          nxt = (rem == 9'd1) ? S_DONE : S_DIR;
            default:        nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            rem     <= 9'd0;
            dir_x   <= 9'd0;
            dir_y   <= 9'd0;
            fl      <= 16'd0;
            fr      <= 16'd0;
            ant_go  <= 1'b0;
            fit_go  <= 1'b0;
            fit_sel <= 1'b0;
            upd_go  <= 1'b0;
            upd_sgn <= 1'b0;
            f_best  <= 16'h7F80;
            clk_cnt <= 32'd0;
        end else begin
            state   <= nxt;
            // go pulses are registered off the next state so they coincide with the REQ cycle
            ant_go  <= (nxt == S_ANT_REQ);
            fit_go  <= (nxt == S_FL_REQ) || (nxt == S_FR_REQ);
            fit_sel <= (nxt == S_FR_REQ) || (nxt == S_FR_WAIT);
            upd_go  <= (nxt == S_UPD_REQ);
            if (state == S_SEED) begin
                rem     <= count;
                dir_x   <= (seed1 == 9'd0) ? 9'd1 : seed1;
                dir_y   <= (seed2 == 9'd0) ? 9'd1 : seed2;
                f_best  <= 16'h7F80;
                clk_cnt <= 32'd1;
            end else if (busy) begin
                clk_cnt <= (&clk_cnt) ? clk_cnt : clk_cnt + 32'd1;
            end
            if (state == S_DIR) begin
                dir_x <= {dir_x[7:0], dir_x[8] ^ dir_x[4]};
                dir_y <= {dir_y[7:0], dir_y[8] ^ dir_y[4]};
            end
            if (state == S_FL_WAIT && fit_done)
                fl <= fit_res;
            if (state == S_FR_WAIT && fit_done)
                fr <= fit_res;
            if (state == S_CMP) begin
                upd_sgn <= fr_lt;
                if (lt(m, f_best))
                    f_best <= m;
            end
            if (state == S_CHK)
                rem <= rem - 9'd1;
        end
    end
endmodule

// File: tb/tb_bas_seq_ctrl.sv
// tb_bas_seq_ctrl: directed, table-driven bench for bas_seq_ctrl with delay-configurable responders.
module tb_bas_seq_ctrl;
    logic        clk = 0;
    logic        reset = 1;
    logic        start = 0;
    logic [8:0]  count = 0, seed1 = 0, seed2 = 0;
    logic [8:0]  dir_x, dir_y;
    logic        ant_go, fit_go, fit_sel, upd_go, upd_sgn, busy, done;
    logic        ant_done = 0, fit_done = 0, upd_done = 0;
    logic [15:0] fit_res = 0;
    logic [15:0] f_best;
    logic [31:0] clk_cnt;

    bas_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .count(count), .seed1(seed1), .seed2(seed2),
        .dir_x(dir_x), .dir_y(dir_y), .ant_go(ant_go), .ant_done(ant_done),
        .fit_go(fit_go), .fit_sel(fit_sel), .fit_done(fit_done), .fit_res(fit_res),
        .upd_go(upd_go), .upd_sgn(upd_sgn), .upd_done(upd_done),
        .f_best(f_best), .clk_cnt(clk_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int lat = 1;
    int fit_base = 0;
    logic [15:0] fit_vals[8];
    int n_ant = 0, n_fit = 0, n_upd = 0, n_busy = 0, n_go = 0, n_selbad = 0;
    int ant_cd = 0, fit_cd = 0, upd_cd = 0, pend_idx = 0;

    // responders and pulse monitor: done arrives lat cycles after the go pulse
    always @(negedge clk) begin
        ant_done = 0;
        fit_done = 0;
        upd_done = 0;
        n_go += int'(ant_go) + int'(fit_go) + int'(upd_go);
        if (reset) begin
            ant_cd = 0;
            fit_cd = 0;
            upd_cd = 0;
        end else begin
            if (ant_cd > 0) begin ant_cd--; ant_done = (ant_cd == 0); end
            if (upd_cd > 0) begin upd_cd--; upd_done = (upd_cd == 0); end
            if (fit_cd > 0) begin
                fit_cd--;
                if (fit_cd == 0) begin
                    fit_done = 1;
                    fit_res  = fit_vals[pend_idx % 8];
                end
            end
            if (ant_go) begin n_ant++; ant_cd = lat; end
            if (upd_go) begin n_upd++; upd_cd = lat; end
            if (fit_go) begin
                pend_idx = n_fit - fit_base;
                if (fit_sel != pend_idx[0]) n_selbad++;
                n_fit++;
                fit_cd = lat;
            end
            if (busy) n_busy++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int b_ant, b_fit, b_upd, b_busy, b_sel;

    task automatic run(input logic [8:0] c, input logic [8:0] s1, input logic [8:0] s2,
                       input int l, input int poke);
        int cyc;
        @(negedge clk);
        lat = l;
        fit_base = n_fit;
        b_ant = n_ant; b_fit = n_fit; b_upd = n_upd; b_busy = n_busy; b_sel = n_selbad;
        count = c; seed1 = s1; seed2 = s2; start = 1;
        @(negedge clk);
        start = 0;
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == poke);
        end
        start = 0;
        check("run_done", 32'(done), 32'h1);
    endtask

    task automatic scen1(input string tag);
        fit_vals[0] = 16'h4000; fit_vals[1] = 16'h3F80;
        fit_vals[2] = 16'h4100; fit_vals[3] = 16'h4080;
        fit_vals[4] = 16'h3F00; fit_vals[5] = 16'h4000;
        run(9'd3, 9'h021, 9'h14E, 1, 0);
        check({tag, "_clk_cnt"}, clk_cnt, 32'd34);
        check({tag, "_busy_cyc"}, 32'(n_busy - b_busy), 32'd34);
        check({tag, "_ant_go"}, 32'(n_ant - b_ant), 32'd3);
        check({tag, "_fit_go"}, 32'(n_fit - b_fit), 32'd6);
        check({tag, "_upd_go"}, 32'(n_upd - b_upd), 32'd3);
        check({tag, "_fit_sel"}, 32'(n_selbad - b_sel), 32'd0);
        check({tag, "_f_best"}, 32'(f_best), 32'h3F00);
        check({tag, "_upd_sgn"}, 32'(upd_sgn), 32'h0);
        check({tag, "_dir_x"}, 32'(dir_x), 32'h108);
        check({tag, "_dir_y"}, 32'(dir_y), 32'h076);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    typedef struct {
        logic [8:0]  s1, s2;
        logic [15:0] fl, fr;
        logic        sgn;
        logic [15:0] best;
        logic [8:0]  dx, dy;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int g0, cyc;
        vecs[0] = '{9'h000, 9'h100, 16'h41C8, 16'h41A0, 1'b1, 16'h41A0, 9'h002, 9'h001};
        vecs[1] = '{9'h021, 9'h14E, 16'hC120, 16'hC100, 1'b0, 16'hC120, 9'h042, 9'h09D};
        vecs[2] = '{9'h001, 9'h001, 16'h3F80, 16'h7FC1, 1'b0, 16'h3F80, 9'h002, 9'h002};
        vecs[3] = '{9'h1FF, 9'h1FF, 16'h8000, 16'h0000, 1'b0, 16'h8000, 9'h1FE, 9'h1FE};
        vecs[4] = '{9'h010, 9'h010, 16'h7F81, 16'h4000, 1'b0, 16'h7F80, 9'h021, 9'h021};
        vecs[5] = '{9'h100, 9'h021, 16'h3F80, 16'hBF80, 1'b1, 16'hBF80, 9'h001, 9'h042};
        for (int i = 0; i < 8; i++) fit_vals[i] = 16'h3F80;

        @(posedge clk); #1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_f_best", 32'(f_best), 32'h7F80);
        check("rst_clk_cnt", clk_cnt, 32'h0);
        check("rst_dir_x", 32'(dir_x), 32'h0);
        check("rst_gos", 32'({ant_go, fit_go, upd_go, fit_sel, upd_sgn}), 32'h0);
        @(negedge clk);
        reset = 0;

        scen1("s1");

        for (int i = 0; i < 6; i++) begin
            fit_vals[0] = vecs[i].fl;
            fit_vals[1] = vecs[i].fr;
            run(9'd1, vecs[i].s1, vecs[i].s2, 1, 0);
            check($sformatf("v%0d_upd_sgn", i), 32'(upd_sgn), 32'(vecs[i].sgn));
            check($sformatf("v%0d_f_best", i), 32'(f_best), 32'(vecs[i].best));
            check($sformatf("v%0d_clk_cnt", i), clk_cnt, 32'd12);
            check($sformatf("v%0d_dir_x", i), 32'(dir_x), 32'(vecs[i].dx));
            check($sformatf("v%0d_dir_y", i), 32'(dir_y), 32'(vecs[i].dy));
        end

        run(9'd0, 9'h055, 9'h0AA, 1, 0);
        check("c0_clk_cnt", clk_cnt, 32'd1);
        check("c0_ant_go", 32'(n_ant - b_ant), 32'd0);
        check("c0_dir_x", 32'(dir_x), 32'h055);
        check("c0_f_best", 32'(f_best), 32'h7F80);

        run(9'd2, 9'h021, 9'h14E, 5, 10);
        check("slow_clk_cnt", clk_cnt, 32'd55);
        check("slow_busy_cyc", 32'(n_busy - b_busy), 32'd55);
        check("slow_ant_go", 32'(n_ant - b_ant), 32'd2);
        check("slow_fit_go", 32'(n_fit - b_fit), 32'd4);
        repeat (3) @(negedge clk);
        check("done_hold_cnt", clk_cnt, 32'd55);
        check("done_hold", 32'(done), 32'h1);

        // abort a run in the second iteration's FR_WAIT
        fit_vals[0] = 16'h4000; fit_vals[1] = 16'h3F80;
        fit_vals[2] = 16'h4100; fit_vals[3] = 16'h4080;
        @(negedge clk);
        lat = 5;
        fit_base = n_fit;
        count = 9'd3; seed1 = 9'h021; seed2 = 9'h14E; start = 1;
        @(negedge clk);
        start = 0;
        cyc = 0;
        while (!(fit_sel && !fit_go && (n_fit - fit_base) >= 4) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_fr_wait", 32'(fit_sel && busy), 32'h1);
        check("pre_rst_f_best", 32'(f_best), 32'h3F80);
        #2 reset = 1;
        #1;
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        check("arst_f_best", 32'(f_best), 32'h7F80);
        check("arst_clk_cnt", clk_cnt, 32'h0);
        check("arst_dir", 32'({dir_x, dir_y}), 32'h0);
        check("arst_gos", 32'({ant_go, fit_go, upd_go, fit_sel, upd_sgn}), 32'h0);
        g0 = n_go;
        repeat (3) @(negedge clk);
        check("arst_no_go", 32'(n_go - g0), 32'd0);
        reset = 0;

        scen1("s1b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
